clk_gate_ctrl: RTL and testbench

//  Generates the enable for the latch-based clock gate of a gated domain, e.g. the ALU.

---
 rtl/clk_gate_pkg.sv | 17 +
 rtl/clk_gate_if.sv | 23 ++
 rtl/clk_gate_cnt.sv | 37 +++
 rtl/clk_gate_ctrl.sv | 104 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller.
// Holds the FSM state encoding and the default timing parameters.
package clk_gate_pkg;

    localparam int STATE_W              = 2;
    localparam int DEFAULT_WAKE_LAT     = 2;
    localparam int DEFAULT_IDLE_TIMEOUT = 8;
    localparam int DEFAULT_CNT_W        = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_WAKE   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_DRAIN  = 2'b11
    } state_e;

endpackage

// File: rtl/clk_gate_if.sv
// Request/status bundle between the system controller (master) and the
// clock-gate enable controller (slave).
interface clk_gate_if;
    import clk_gate_pkg::*;

    logic               WAKE_REQ;
    logic               BUSY;
    logic               TEST_EN;
    logic               CLK_EN;
    logic               READY;
    logic [STATE_W-1:0] STATE;

    modport master (
        output WAKE_REQ, BUSY, TEST_EN,
        input  CLK_EN, READY, STATE
    );

    modport slave (
        input  WAKE_REQ, BUSY, TEST_EN,
        output CLK_EN, READY, STATE
    );

endinterface

// File: rtl/clk_gate_cnt.sv
// Loadable down-counter used for the wake settle and idle drain timers.
// Saturates at zero; load has priority over decrement.
module clk_gate_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable generator for the latch-based clock gate of a gated domain.
// Opens on wake, reports READY after settling, closes after a programmable idle drain.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int WAKE_LAT     = DEFAULT_WAKE_LAT,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    clk_gate_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_LAT - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        ready_d      = ready_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = WAKE_LD;

        case (state_q)
            ST_IDLE: begin
                if (bus.WAKE_REQ) begin
                    state_d  = ST_WAKE;
                    en_d     = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            // Inputs are ignored while settling: a dropped request still goes via ACTIVE.
            ST_WAKE: begin
                if (cnt_zero) begin
                    state_d = ST_ACTIVE;
                    ready_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!bus.WAKE_REQ && !bus.BUSY) begin
                    state_d      = ST_DRAIN;
                    cnt_load     = 1'b1;
                    cnt_load_val = IDLE_LD;
                end
            end
            ST_DRAIN: begin
                // Renewed activity outranks expiry so the gate never closes under load.
                if (bus.WAKE_REQ || bus.BUSY) begin
                    state_d = ST_ACTIVE;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    ready_d = 1'b0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    clk_gate_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Scan override is the only unregistered path to the gate enable.
    assign bus.CLK_EN = en_q | bus.TEST_EN;
    assign bus.READY  = ready_q;
    assign bus.STATE  = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: an open/settle/idle-run model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_clk_gate_ctrl;

    localparam int WL = 2;
    localparam int IT = 8;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;

    clk_gate_if bus ();

    clk_gate_ctrl #(
        .WAKE_LAT     (WL),
        .IDLE_TIMEOUT (IT),
        .CNT_W        (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: is the gate open, has it settled, how many edges since opening,
    // and how long the current run of idle samples is while settled.
    bit m_open, m_ready;
    int m_since, m_idle;

    always @(posedge CLK) begin
        if (!RST) begin
            m_open = 0; m_ready = 0; m_since = 0; m_idle = 0;
        end else if (!m_open) begin
            if (bus.WAKE_REQ) begin
                m_open = 1; m_since = 0; m_idle = 0;
            end
        end else if (!m_ready) begin
            m_since++;
            if (m_since == WL) m_ready = 1;
        end else if (!bus.WAKE_REQ && !bus.BUSY) begin
            m_idle++;
            if (m_idle == IT + 1) begin
                m_open = 0; m_ready = 0; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    end

    function automatic int exp_state();
        if (!m_open)       return 0;
        if (!m_ready)      return 1;
        if (m_idle == 0)   return 2;
        return 3;
    endfunction

    // Capture a few time units after the edge, compare at the falling edge.
    logic en_cap, te_cap;
    always @(posedge CLK) begin
        #4;
        en_cap = bus.CLK_EN;
        te_cap = bus.TEST_EN;
    end

    always @(negedge CLK) begin
        check("model_state",  int'(bus.STATE),  exp_state());
        check("model_ready",  int'(bus.READY),  int'(m_ready));
        check("model_clk_en", int'(bus.CLK_EN), int'(m_open | bus.TEST_EN));
        check("ready_implies_clk_en", int'(!bus.READY || bus.CLK_EN), 1);
        if (!te_cap && !bus.TEST_EN)
            check("clk_en_stable_between_edges", int'(bus.CLK_EN), int'(en_cap));
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input int en, input int rdy, input int st);
        check({tag, "_clk_en"}, int'(bus.CLK_EN), en);
        check({tag, "_ready"},  int'(bus.READY),  rdy);
        check({tag, "_state"},  int'(bus.STATE),  st);
    endtask

    initial begin
        RST = 1'b0; bus.WAKE_REQ = 1'b1; bus.BUSY = 1'b0; bus.TEST_EN = 1'b0;

        // Reset held for two edges with a pending request
        step(1); expect_out("rst_e0", 0, 0, 0);
        step(1); expect_out("rst_e1", 0, 0, 0);
        bus.WAKE_REQ = 1'b0; RST = 1'b1;
        step(1); expect_out("idle", 0, 0, 0);

        // Wake: enable at edge 0, READY at edge WAKE_LAT
        bus.WAKE_REQ = 1'b1;
        step(1); expect_out("wake_e0", 1, 0, 1);
        step(1); expect_out("wake_e1", 1, 0, 1);
        step(1); expect_out("wake_e2", 1, 1, 2);
        step(2); expect_out("active_hold", 1, 1, 2);

        // Full drain: closes at edge IDLE_TIMEOUT
        bus.WAKE_REQ = 1'b0;
        step(1); expect_out("drain_e0", 1, 1, 3);
        step(7); expect_out("drain_e7", 1, 1, 3);
        step(1); expect_out("drain_e8", 0, 0, 0);

        // BUSY alone in IDLE is ignored
        bus.BUSY = 1'b1;
        step(2); expect_out("busy_idle", 0, 0, 0);
        bus.BUSY = 1'b0;

        // Re-wake race: BUSY at the expiry edge keeps the gate open
        bus.WAKE_REQ = 1'b1;
        step(3); expect_out("race_active", 1, 1, 2);
        bus.WAKE_REQ = 1'b0;
        step(8); expect_out("race_e7", 1, 1, 3);
        bus.BUSY = 1'b1;
        step(1); expect_out("race_busy_e8", 1, 1, 2);

        // WAKE_REQ at the expiry edge also wins
        bus.BUSY = 1'b0;
        step(8); expect_out("race2_e7", 1, 1, 3);
        bus.WAKE_REQ = 1'b1;
        step(1); expect_out("race2_wake_e8", 1, 1, 2);
        bus.WAKE_REQ = 1'b0;
        step(9); expect_out("race2_closed", 0, 0, 0);

        // Request dropped during WAKE still passes through ACTIVE, then drains
        bus.WAKE_REQ = 1'b1;
        step(1); expect_out("drop_e0", 1, 0, 1);
        bus.WAKE_REQ = 1'b0;
        step(1); expect_out("drop_e1", 1, 0, 1);
        step(1); expect_out("drop_e2", 1, 1, 2);
        step(1); expect_out("drop_e3", 1, 1, 3);
        step(8); expect_out("drop_closed", 0, 0, 0);

        // Reset mid-WAKE aborts; next wake takes the full latency again
        bus.WAKE_REQ = 1'b1;
        step(1); expect_out("rwake_e0", 1, 0, 1);
        RST = 1'b0;
        step(1); expect_out("rwake_rst", 0, 0, 0);
        RST = 1'b1;
        step(1); expect_out("rwake2_e0", 1, 0, 1);
        step(1); expect_out("rwake2_e1", 1, 0, 1);
        step(1); expect_out("rwake2_e2", 1, 1, 2);

        // Reset mid-DRAIN aborts as well
        bus.WAKE_REQ = 1'b0;
        step(3); expect_out("rdrain_pre", 1, 1, 3);
        RST = 1'b0;
        step(1); expect_out("rdrain_rst", 0, 0, 0);
        RST = 1'b1;
        step(1);

        // Scan override: immediate, no effect on FSM or READY
        bus.TEST_EN = 1'b1;
        #1; expect_out("test_on", 1, 0, 0);
        step(2); expect_out("test_hold", 1, 0, 0);
        bus.TEST_EN = 1'b0;
        #1; expect_out("test_off", 0, 0, 0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
